imem_loader: RTL

Byte-stream program loader: the write side of the instruction memory that the single-cycle core fetches from. Accepts a framed byte stream (length, little-endian instruction words, checksum), assembles 32-bit words and writes them to consecutive instruction-memory addresses from 0. While loading, it holds the core via `cpu_hold`, which is ORed into the core's `rst`. It reports completion and errors.

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (length, LE words, checksum) and
// writes the assembled 32-bit words to instruction memory while holding the core.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req_i,
   input  logic [7:0]        byte_in_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   words_loaded_o
);

   typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM} state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [23:0]       asm_q, asm_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [7:0]        sum_q, sum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   wl_q, wl_d;

   logic [15:0]       len_full;
   logic [ADDR_W:0]   wl_inc;

   assign len_full = {byte_in_i, len_lo_q};
   assign wl_inc   = wl_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      asm_d    = asm_q;
      bcnt_d   = bcnt_q;
      sum_d    = sum_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      done_d   = 1'b0;
      err_d    = err_q;
      wl_d     = wl_q;
      case (state_q)
         S_IDLE: begin
            if (load_req_i) begin
               state_d = S_LEN0;
               err_d   = 1'b0;
               wl_d    = '0;
               sum_d   = '0;
               bcnt_d  = '0;
            end
         end
         S_LEN0: begin
            if (byte_valid_i) begin
               len_lo_d = byte_in_i;
               state_d  = S_LEN1;
            end
         end
         S_LEN1: begin
            if (byte_valid_i) begin
               if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  len_d   = len_full[ADDR_W:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_valid_i) begin
               sum_d  = sum_q + byte_in_i;
               bcnt_d = bcnt_q + 2'd1;
               // Bytes arrive LSB first, so shift in from the top
               asm_d  = {byte_in_i, asm_q[23:8]};
               if (bcnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = wl_q[ADDR_W-1:0];
                  wdata_d = {byte_in_i, asm_q};
                  wl_d    = wl_inc;
                  if (wl_inc == len_q) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (byte_valid_i) begin
               if (byte_in_i != sum_q) err_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         asm_q    <= '0;
         bcnt_q   <= '0;
         sum_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wl_q     <= '0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         asm_q    <= asm_d;
         bcnt_q   <= bcnt_d;
         sum_q    <= sum_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wl_q     <= wl_d;
      end
   end

   assign byte_ready_o   = (state_q != S_IDLE);
   assign busy_o         = (state_q != S_IDLE);
   assign cpu_hold_o     = (state_q != S_IDLE);
   assign imem_we_o      = we_q;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = wdata_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign words_loaded_o = wl_q;

endmodule
